// File: rtl/sprite_pkg.sv
// Types and helpers shared by the sprite rendering blocks.
// Coordinates are carried at 11 bits so that position + extent never wraps.
package sprite_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } anim_state_t;

  typedef logic [10:0] coord_t;

  function automatic int frame_size(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// Animation frame sequencer: steps through the strip on frame_tick while
// the object moves, and latches facing once per video frame.
module sprite_frame_seq
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int FIDX_W     = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic              direction,
  output logic [FIDX_W-1:0] frameIdx,
  output logic              dirLatched
);

  localparam int HOLD_W =
    (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(FRAME_HOLD - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST =
    FIDX_W'(NUM_FRAMES - 1);

  anim_state_t       r_state;
  anim_state_t       w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [FIDX_W-1:0] r_fidx;
  logic [FIDX_W-1:0] w_fidx_nxt;
  logic              r_dir;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_tick) begin
      unique case (r_state)
        IDLE: if (moving)  w_state_nxt = RUN;
        RUN:  if (!moving) w_state_nxt = IDLE;
      endcase
    end
  end

  // Entering RUN, leaving RUN and idling all restart at frame 0.
  always_comb begin
    w_hold_nxt = r_hold;
    w_fidx_nxt = r_fidx;
    if (frame_tick) begin
      if (r_state == RUN && moving) begin
        if (r_hold == HOLD_LAST) begin
          w_hold_nxt = '0;
          w_fidx_nxt = (r_fidx == FIDX_LAST) ?
                       '0 : r_fidx + 1'b1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end else begin
        w_hold_nxt = '0;
        w_fidx_nxt = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hold <= '0;
      r_fidx <= '0;
      r_dir  <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_fidx <= w_fidx_nxt;
      if (frame_tick) r_dir <= direction;
    end
  end

  assign frameIdx   = r_fidx;
  assign dirLatched = r_dir;

endmodule

// File: rtl/sprite_anim_addr.sv
// Animated sprite ROM address generator: hit test, optional mirroring
// and strip addressing, registered once toward the ROM.
module sprite_anim_addr
  import sprite_pkg::*;
#(
  parameter int SPRITE_W    = 68,
  parameter int SPRITE_H    = 34,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 6,
  parameter int BASE_OFFSET = 0,
  parameter int LEFT_OFFSET = 9248,
  parameter int MIRROR_MODE = 1,
  parameter int ADDR_W      = 21,
  localparam int FIDX_W =
    (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              moving,
  input  logic              direction,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  output logic              spriteOn,
  output logic [ADDR_W-1:0] spriteAddress,
  output logic [FIDX_W-1:0] frameIdx
);

  localparam int FRAME_SZ = frame_size(SPRITE_W, SPRITE_H);
  localparam coord_t W11 = coord_t'(SPRITE_W);
  localparam coord_t H11 = coord_t'(SPRITE_H);

  logic [FIDX_W-1:0] w_fidx;
  logic              w_dir;
  coord_t            w_dx;
  coord_t            w_dy;
  coord_t            w_px;
  coord_t            w_py;
  coord_t            w_col;
  coord_t            w_row;
  coord_t            w_col_m;
  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;
  logic              r_on;
  logic [ADDR_W-1:0] r_addr;

  sprite_frame_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FIDX_W     (FIDX_W)
  ) u_seq (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .moving     (moving),
    .direction  (direction),
    .frameIdx   (w_fidx),
    .dirLatched (w_dir)
  );

  assign w_dx = {1'b0, DrawX};
  assign w_dy = {1'b0, DrawY};
  assign w_px = {1'b0, PosX};
  assign w_py = {1'b0, PosY};

  assign w_hit = (w_dx >= w_px) && (w_dx < w_px + W11) &&
                 (w_dy >= w_py) && (w_dy < w_py + H11);

  assign w_col   = w_dx - w_px;
  assign w_row   = w_dy - w_py;
  assign w_col_m = (MIRROR_MODE != 0 && w_dir) ?
                   W11 - 11'd1 - w_col : w_col;

  // Constant-operand products only; no variable x variable multiply.
  always_comb begin
    w_addr = ADDR_W'(BASE_OFFSET)
           + ADDR_W'(FRAME_SZ * int'(w_fidx))
           + ADDR_W'(SPRITE_W * int'(w_row))
           + ADDR_W'(w_col_m);
    if (MIRROR_MODE == 0 && w_dir)
      w_addr = w_addr + ADDR_W'(LEFT_OFFSET);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_on   <= 1'b0;
      r_addr <= '0;
    end else begin
      r_on   <= w_hit;
      r_addr <= w_hit ? w_addr : '0;
    end
  end

  assign spriteOn      = r_on;
  assign spriteAddress = r_addr;
  assign frameIdx      = w_fidx;

endmodule

// File: doc/sprite_anim_addr.md
# sprite_anim_addr

Parametrised sprite address generator that succeeds the single-frame player animation blocks. It takes the raster position and a sprite's screen position, then produces a registered in-sprite flag and a ROM address. The address walks a multi-frame animation strip while the sprite is moving and supports either hardware horizontal mirroring or a separate left-facing strip. It sits between the game-logic position registers and the sprite ROM / colour mapper, one instance per animated object.

## Interface
- SPRITE_W, 68, sprite width in pixels (≥1)
- SPRITE_H, 34, sprite height in pixels (≥1)
- NUM_FRAMES, 4, animation frames per strip (≥1)
- FRAME_HOLD, 6, frame_tick pulses each animation frame is held (≥1)
- BASE_OFFSET, 0, ROM word address of frame 0, right-facing
- LEFT_OFFSET, 9248, added for left-facing when MIRROR_MODE=0
- MIRROR_MODE, 1, 1 = mirror the right strip for left-facing; 0 = use the left strip at LEFT_OFFSET
- ADDR_W, 21, spriteAddress width
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-Clk pulse at start of each video frame (vsync edge)
- moving  in  1  object is moving (level)
- direction  in  1  0 = right-facing, 1 = left-facing
- DrawX, DrawY  in  10 each  current raster pixel
- PosX, PosY  in  10 each  sprite top-left corner
- spriteOn  out  1  registered: raster pixel lies inside sprite
- spriteAddress  out  ADDR_W  registered ROM address for that pixel
- frameIdx  out  $clog2(NUM_FRAMES) (min 1)  current animation frame

## Operation
- Frame sequencer FSM, states IDLE and RUN; it updates only on a frame_tick cycle.
  - IDLE: frameIdx=0, hold counter=0. If moving is sampled high at frame_tick, go to RUN.
  - RUN, at each frame_tick with moving high: if holdCnt==FRAME_HOLD-1, then holdCnt←0 and frameIdx←(frameIdx==NUM_FRAMES-1)?0:frameIdx+1. Otherwise holdCnt+1.
  - RUN, at frame_tick with moving low: go to IDLE; frameIdx←0 and holdCnt←0 in the same cycle.
- dirLatched ← direction at every frame_tick, including in IDLE. A direction change mid-frame takes effect from the next frame and never tears the current frame.
- moving or direction changes between ticks are ignored.
- Hit test uses 11-bit unsigned arithmetic, so PosX+SPRITE_W cannot wrap:
  - DrawX ≥ PosX and DrawX < PosX+SPRITE_W
  - DrawY ≥ PosY and DrawY < PosY+SPRITE_H
  - A sprite partially off the right/bottom edge is clipped. It never aliases to column 0.
- col = DrawX−PosX and row = DrawY−PosY. If MIRROR_MODE=1 and dirLatched=1, col ← SPRITE_W−1−col.
- Address = BASE_OFFSET + frameIdx·SPRITE_W·SPRITE_H + row·SPRITE_W + col, plus LEFT_OFFSET when MIRROR_MODE=0 and dirLatched=1. The result is truncated to ADDR_W.
- When there is no hit, spriteAddress=0 and spriteOn=0.

## Timing
- Reset values: spriteOn=0, spriteAddress=0, frameIdx=0, FSM=IDLE, holdCnt=0, dirLatched=0.
- Reset wins over a simultaneous frame_tick.
- spriteOn and spriteAddress have 1-Clk latency from DrawX/DrawY/PosX/PosY. Both come from the same register stage, so they are always coherent.
- frameIdx and dirLatched change only in the cycle after a frame_tick edge. Pixels in the cycle after that tick use the new values.
- The first frame_tick with moving high enters RUN and shows frame 0. Each frame is shown for FRAME_HOLD ticks.
- NUM_FRAMES=1: frameIdx stays 0 and FSM transitions still occur.
- FRAME_HOLD=1: advance on every tick.
- Reset mid-animation: frame 0, right-facing, IDLE on the next cycle.
- Multiplies use constant operands only (SPRITE_W, SPRITE_W·SPRITE_H). There is no variable×variable multiplier.

## Structure
- Package sprite_pkg holds:
  - anim_state_t enum {IDLE, RUN}
  - a localparam helper for frame size (SPRITE_W·SPRITE_H)
  - the 11-bit coordinate type shared with other sprite blocks
- Sub-module sprite_frame_seq contains the FSM, holdCnt, frameIdx and dirLatched.
- The top level holds the hit test, mirroring, the address adder and the output register.

## Test plan
- Reset, PosX=100, PosY=50, raster at (100,50) → one Clk later: spriteOn=1, spriteAddress=0. Raster at (167,83) → spriteAddress=2311. Raster at (168,50) → spriteOn=0, spriteAddress=0.
- Hold moving=1 and pulse frame_tick 30 times with FRAME_HOLD=6, NUM_FRAMES=4 → frameIdx goes 0,1,2,3,0 at ticks 1,7,13,19,25. At (100,50) in frame 2 → spriteAddress=4624.
- MIRROR_MODE=1, direction=1 set mid-frame → address at (100,50) stays 0 until the next frame_tick, then becomes 67. MIRROR_MODE=0 → becomes 9248.
- Drop moving while in frame 3, then pulse frame_tick → FSM=IDLE, frameIdx=0 on the following cycle.
- PosX=1000, raster at DrawX=1023 → spriteOn=1, col=23. PosX+SPRITE_W overflow beyond 1023 gives no wrapped hit at DrawX=0..3.
- Assert Reset together with frame_tick while in RUN at frameIdx=2 → all outputs are reset values on the next cycle and spriteOn=0.
